// File: rtl/lion_fetch_aligner.sv
// Instruction-fetch realigner: word-aligned fetches into a 4-halfword FIFO,
// issuing whole 16/32-bit RV32IC instructions with their PC to decode.
module lion_fetch_aligner #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_insn,
   output logic [31:0] out_pc,
   output logic        out_compressed
);

   localparam logic [31:0] ResetFetch = {RESET_PC[31:2], 2'b00};
   localparam logic [31:0] ResetPc    = {RESET_PC[31:1], 1'b0};

   logic [63:0] buf_q, buf_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic [31:0] pc_q, pc_d;
   logic        skip_lo_q, skip_lo_d;

   logic [15:0] hw0, hw1;
   logic        head_is32, issue_ok, out_fire, mem_fire, push_lo, push_hi;
   logic [31:0] insn;
   logic [1:0]  pop_n;
   logic [2:0]  rem, hi_idx;
   logic [63:0] shifted;

   always_comb begin
      hw0       = buf_q[15:0];
      hw1       = buf_q[31:16];
      head_is32 = (hw0[1:0] == 2'b11);
      issue_ok  = head_is32 ? (cnt_q >= 3'd2) : (cnt_q >= 3'd1);
      insn      = head_is32 ? {hw1, hw0} : {16'h0000, hw0};

      out_valid      = resetn && !redirect_valid && issue_ok;
      out_insn       = resetn ? insn : 32'h0;
      out_pc         = resetn ? pc_q : ResetPc;
      out_compressed = (out_insn[1:0] != 2'b11);

      // Threshold of 2 leaves room for a full word push after any pop.
      mem_valid = resetn && !redirect_valid && (cnt_q <= 3'd2);
      mem_instr = mem_valid;
      mem_addr  = fetch_addr_q;
   end

   always_comb begin
      out_fire = out_valid && out_ready;
      mem_fire = mem_valid && mem_ready;
      pop_n    = out_fire ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;
      rem      = cnt_q - {1'b0, pop_n};
      shifted  = buf_q >> {pop_n, 4'b0000};
      push_lo  = mem_fire && !skip_lo_q;
      push_hi  = mem_fire;
      hi_idx   = rem + {2'b00, push_lo};

      buf_d = shifted;
      for (int i = 0; i < 4; i++) begin
         if (push_lo && (rem == 3'(i))) begin
            buf_d[16*i +: 16] = mem_rdata[15:0];
         end
         if (push_hi && (hi_idx == 3'(i))) begin
            buf_d[16*i +: 16] = mem_rdata[31:16];
         end
      end
      cnt_d        = hi_idx + {2'b00, push_hi};
      fetch_addr_d = mem_fire ? fetch_addr_q + 32'd4 : fetch_addr_q;
      skip_lo_d    = mem_fire ? 1'b0 : skip_lo_q;
      pc_d         = out_fire ? pc_q + (head_is32 ? 32'd4 : 32'd2) : pc_q;

      if (redirect_valid) begin
         buf_d        = '0;
         cnt_d        = 3'd0;
         fetch_addr_d = redirect_pc & ~32'h3;
         skip_lo_d    = redirect_pc[1];
         pc_d         = redirect_pc & ~32'h1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         buf_q        <= '0;
         cnt_q        <= 3'd0;
         fetch_addr_q <= ResetFetch;
         skip_lo_q    <= RESET_PC[1];
         pc_q         <= ResetPc;
      end else begin
         buf_q        <= buf_d;
         cnt_q        <= cnt_d;
         fetch_addr_q <= fetch_addr_d;
         skip_lo_q    <= skip_lo_d;
         pc_q         <= pc_d;
      end
   end

endmodule

// File: tb/tb_lion_fetch_aligner.sv
// Directed bench for lion_fetch_aligner: a PC-walking memory model fills a
// scoreboard of expected instructions, popped on every output handshake.
module tb_lion_fetch_aligner;

   logic        clk = 1'b0;
   logic        resetn, redirect_valid, mem_ready, out_ready;
   logic [31:0] redirect_pc;
   logic        mem_valid, mem_instr, out_valid, out_compressed;
   logic [31:0] mem_addr, mem_rdata, out_insn, out_pc;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned fires  = 0;

   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] pc;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   lion_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_valid      (mem_valid),
      .mem_instr      (mem_instr),
      .mem_addr       (mem_addr),
      .mem_ready      (mem_ready),
      .mem_rdata      (mem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_insn       (out_insn),
      .out_pc         (out_pc),
      .out_compressed (out_compressed)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h0000_0513;
         32'h0000_0004: mem_word = 32'h0505_0485;
         32'h0000_0100: mem_word = 32'h0513_0001;
         32'h0000_0104: mem_word = 32'h0001_0000;
         default:       mem_word = {a[21:2], 12'h013};
      endcase
   endfunction

   assign mem_rdata = mem_word(mem_addr);

   function automatic logic [15:0] hw_at(input logic [31:0] p);
      logic [31:0] w;
      w = mem_word({p[31:2], 2'b00});
      hw_at = p[1] ? w[31:16] : w[15:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Replace the expected stream with the instruction sequence starting at pc.
   task automatic launch(input logic [31:0] start);
      logic [31:0] p;
      logic [15:0] lo;
      exp_t        e;
      sb.delete();
      p = {start[31:1], 1'b0};
      for (int i = 0; i < 64; i++) begin
         lo   = hw_at(p);
         e.pc = p;
         if (lo[1:0] == 2'b11) begin
            e.insn = {hw_at(p + 32'd2), lo};
            p      = p + 32'd4;
         end else begin
            e.insn = {16'h0000, lo};
            p      = p + 32'd2;
         end
         sb.push_back(e);
      end
   endtask

   task automatic cycle();
      exp_t e;
      #1;
      if (out_valid && out_ready) begin
         fires++;
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            chk("sb_insn", out_insn, e.insn);
            chk("sb_pc", out_pc, e.pc);
            chk("sb_compressed", {31'b0, out_compressed}, {31'b0, (e.insn[1:0] != 2'b11)});
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      resetn         = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      mem_ready      = 1'b1;
      out_ready      = 1'b1;
      @(negedge clk);
      @(negedge clk);

      // Reset held
      #1;
      chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
      chk("rst_mem_instr", {31'b0, mem_instr}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_insn", out_insn, 32'h0);
      chk("rst_out_pc", out_pc, 32'h0);

      // Reset release: fetch next cycle, issue the one after
      launch(32'h0);
      resetn = 1'b1;
      #1;
      chk("rel_mem_valid", {31'b0, mem_valid}, 32'd1);
      chk("rel_mem_instr", {31'b0, mem_instr}, 32'd1);
      chk("rel_mem_addr", mem_addr, 32'h0);
      chk("rel_out_valid", {31'b0, out_valid}, 32'd0);
      cycle();
      #1;
      chk("first_valid", {31'b0, out_valid}, 32'd1);
      chk("first_insn", out_insn, 32'h0000_0513);
      chk("first_pc", out_pc, 32'h0);
      chk("first_compressed", {31'b0, out_compressed}, 32'd0);
      cycle();
      #1;
      chk("c0_insn", out_insn, 32'h0000_0485);
      chk("c0_pc", out_pc, 32'h4);
      chk("c0_compressed", {31'b0, out_compressed}, 32'd1);
      cycle();
      #1;
      chk("c1_insn", out_insn, 32'h0000_0505);
      chk("c1_pc", out_pc, 32'h6);
      chk("c1_compressed", {31'b0, out_compressed}, 32'd1);
      repeat (6) cycle();

      // Straddling 32-bit instruction at 0x102
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0102;
      launch(32'h0000_0102);
      #1;
      chk("rd_mem_valid", {31'b0, mem_valid}, 32'd0);
      chk("rd_out_valid", {31'b0, out_valid}, 32'd0);
      cycle();
      redirect_valid = 1'b0;
      #1;
      chk("st_fetch0", mem_addr, 32'h0000_0100);
      chk("st_fetch0_valid", {31'b0, mem_valid}, 32'd1);
      cycle();
      #1;
      chk("st_fetch1", mem_addr, 32'h0000_0104);
      chk("st_wait_valid", {31'b0, out_valid}, 32'd0);
      cycle();
      #1;
      chk("st_valid", {31'b0, out_valid}, 32'd1);
      chk("st_insn", out_insn, 32'h0000_0513);
      chk("st_pc", out_pc, 32'h0000_0102);
      repeat (5) cycle();

      // Backpressure on a stream of 32-bit instructions
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      out_ready      = 1'b0;
      launch(32'h0000_0200);
      cycle();
      redirect_valid = 1'b0;
      repeat (10) cycle();
      #1;
      chk("bp_mem_valid", {31'b0, mem_valid}, 32'd0);
      chk("bp_mem_addr", mem_addr, 32'h0000_0208);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_out_pc", out_pc, 32'h0000_0200);
      out_ready = 1'b1;
      fires     = 0;
      repeat (20) cycle();
      chk("bp_no_gap", 32'(fires), 32'd20);

      // Redirect during a stalled fetch with two halfwords buffered
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0300;
      out_ready      = 1'b0;
      launch(32'h0000_0300);
      cycle();
      redirect_valid = 1'b0;
      cycle();
      mem_ready = 1'b0;
      #1;
      chk("ws_mem_valid", {31'b0, mem_valid}, 32'd1);
      chk("ws_mem_addr", mem_addr, 32'h0000_0304);
      cycle();
      cycle();
      #1;
      chk("ws_hold_valid", {31'b0, mem_valid}, 32'd1);
      chk("ws_hold_addr", mem_addr, 32'h0000_0304);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0404;
      launch(32'h0000_0404);
      #1;
      chk("ws_rd_mem_valid", {31'b0, mem_valid}, 32'd0);
      chk("ws_rd_out_valid", {31'b0, out_valid}, 32'd0);
      cycle();
      redirect_valid = 1'b0;
      mem_ready      = 1'b1;
      out_ready      = 1'b1;
      #1;
      chk("ws_new_addr", mem_addr, 32'h0000_0404);
      chk("ws_new_valid", {31'b0, mem_valid}, 32'd1);
      chk("ws_no_stale", {31'b0, out_valid}, 32'd0);
      repeat (8) cycle();

      // One-cycle reset pulse mid-stream
      resetn = 1'b0;
      launch(32'h0);
      #1;
      chk("rp_mem_valid", {31'b0, mem_valid}, 32'd0);
      chk("rp_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rp_out_pc", out_pc, 32'h0);
      chk("rp_out_insn", out_insn, 32'h0);
      cycle();
      resetn = 1'b1;
      #1;
      chk("rp_fetch_addr", mem_addr, 32'h0);
      chk("rp_fetch_valid", {31'b0, mem_valid}, 32'd1);
      chk("rp_empty", {31'b0, out_valid}, 32'd0);
      cycle();
      #1;
      chk("rp_first_valid", {31'b0, out_valid}, 32'd1);
      chk("rp_first_pc", out_pc, 32'h0);
      repeat (6) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
